// File: rtl/adc_sel_pkg.sv
// adc_sel_pkg
//   Shared types and constants for the ADC display selector.
//   mode_t  : selector FSM states.
//   DP_*    : decimal-point patterns driven to the seven-segment subsystem.
package adc_sel_pkg;
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HOLD   = 2'd2
  } mode_t;

  localparam logic [3:0] DP_NONE = 4'b0000;
  localparam logic [3:0] DP_VOLT = 4'b0010;
  localparam logic [3:0] DP_HOLD = 4'b1000;
endpackage

// File: rtl/adc_display_selector_rise_edge.sv
// rise_edge_detect
//   Rising-edge detector for an already-synchronous, debounced level.
//   clk, rst_n : clock, async active-low reset (history clears to 0)
//   i_lvl      : input level
//   o_rise     : high while i_lvl is high and was low on the previous clock
// History resets low, so a level already high after reset reads as an edge.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_rise
);
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_prev;
endmodule

// File: rtl/adc_display_selector.sv
// adc_display_selector
//   Chooses one of NUM_CH ADC channels for the seven-segment display, either
//   manually (btn_next) or by timed auto-scan, with a freeze (hold_in) mode.
//   clk, reset        : clock, async active-low reset
//   btn_next/btn_mode : clean levels; rising edge = next channel / toggle mode
//   hold_in           : level, freezes the display
//   fmt_select        : format code, 2'b01 = scaled voltage
//   ch_data/ch_valid  : packed channel words and per-channel load strobes
//   sel_out, disp_data, decimal_pt, mode_auto, disp_stale : display outputs
module adc_display_selector
  import adc_sel_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 16,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn_next,
  input  logic                       btn_mode,
  input  logic                       hold_in,
  input  logic [1:0]                 fmt_select,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [$clog2(NUM_CH)-1:0]  sel_out,
  output logic [DATA_W-1:0]          disp_data,
  output logic [3:0]                 decimal_pt,
  output logic                       mode_auto,
  output logic                       disp_stale
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int DW_W  = $clog2(DWELL_CYCLES);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_CH - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

  logic w_next, w_mode;

  rise_edge_detect u_next (.clk(clk), .rst_n(reset), .i_lvl(btn_next), .o_rise(w_next));
  rise_edge_detect u_mode (.clk(clk), .rst_n(reset), .i_lvl(btn_mode), .o_rise(w_mode));

  // Per-channel capture runs in every state, including HOLD.
  logic [NUM_CH-1:0][DATA_W-1:0] r_shadow;
  logic [NUM_CH-1:0]             r_seen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
      r_seen   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          r_shadow[i] <= ch_data[i*DATA_W +: DATA_W];
          r_seen[i]   <= 1'b1;
        end
      end
    end
  end

  mode_t             r_state, r_ret, w_nstate, w_nret;
  logic [SEL_W-1:0]  r_sel, w_nsel, w_sel_inc;
  logic [DW_W-1:0]   r_dwell, w_ndwell;
  logic [DATA_W-1:0] r_disp;
  logic [3:0]        r_dp;
  logic              r_auto, r_stale;

  assign w_sel_inc = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_nstate = r_state;
    w_nret   = r_ret;
    w_nsel   = r_sel;
    w_ndwell = r_dwell;
    case (r_state)
      MANUAL, AUTO: begin
        if (hold_in) begin
          // Hold wins over buttons; remember where to come back to.
          w_nstate = HOLD;
          w_nret   = r_state;
        end else if (r_state == MANUAL) begin
          if (w_next) w_nsel = w_sel_inc;
          if (w_mode) begin
            w_nstate = AUTO;
            w_ndwell = '0;
          end
        end else begin
          // A manual advance restarts the dwell period.
          if (w_next || r_dwell == DWELL_LAST) begin
            w_nsel   = w_sel_inc;
            w_ndwell = '0;
          end else begin
            w_ndwell = r_dwell + 1'b1;
          end
          if (w_mode) w_nstate = MANUAL;
        end
      end
      default: begin
        if (!hold_in) w_nstate = r_ret;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MANUAL;
      r_ret   <= MANUAL;
      r_sel   <= '0;
      r_dwell <= '0;
      r_disp  <= '0;
      r_stale <= 1'b1;
      r_dp    <= DP_NONE;
      r_auto  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_ret   <= w_nret;
      r_sel   <= w_nsel;
      r_dwell <= w_ndwell;
      if (r_state != HOLD) begin
        r_disp  <= r_shadow[r_sel];
        r_stale <= ~r_seen[r_sel];
      end
      // Mode-related outputs track the state being entered so they line up
      // with the registered state.
      r_dp   <= ((fmt_select == 2'b01) ? DP_VOLT : DP_NONE) |
                ((w_nstate == HOLD) ? DP_HOLD : DP_NONE);
      r_auto <= (w_nstate == AUTO) || (w_nstate == HOLD && w_nret == AUTO);
    end
  end

  assign sel_out    = r_sel;
  assign disp_data  = r_disp;
  assign decimal_pt = r_dp;
  assign mode_auto  = r_auto;
  assign disp_stale = r_stale;
endmodule

// File: tb/tb_adc_display_selector.sv
module tb_adc_display_selector;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           btn_next, btn_mode, hold_in;
  logic [1:0]     fmt_select;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   ch_valid;
  logic [1:0]     sel_out;
  logic [W-1:0]   disp_data;
  logic [3:0]     decimal_pt;
  logic           mode_auto, disp_stale;

  adc_display_selector #(.NUM_CH(N), .DATA_W(W), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_mode(btn_mode),
    .hold_in(hold_in), .fmt_select(fmt_select), .ch_data(ch_data),
    .ch_valid(ch_valid), .sel_out(sel_out), .disp_data(disp_data),
    .decimal_pt(decimal_pt), .mode_auto(mode_auto), .disp_stale(disp_stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: channel index, dwell count, an auto flag that survives
  // holds, and a hold flag.
  int         m_sel, m_cnt;
  bit         m_auto, m_hold, m_pn, m_pm, m_stale;
  logic [W-1:0] m_sh[N];
  bit         m_seen[N];
  logic [W-1:0] m_disp;
  logic [3:0] m_dp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sel = 0; m_cnt = 0; m_auto = 0; m_hold = 0; m_pn = 0; m_pm = 0;
    m_disp = '0; m_stale = 1; m_dp = 4'd0;
    for (int i = 0; i < N; i++) begin m_sh[i] = '0; m_seen[i] = 0; end
  endfunction

  function automatic void model_step();
    bit en, em;
    en = btn_next && !m_pn;
    em = btn_mode && !m_pm;
    m_pn = btn_next;
    m_pm = btn_mode;
    if (!m_hold) begin
      m_disp  = m_sh[m_sel];
      m_stale = !m_seen[m_sel];
    end
    if (m_hold) begin
      if (!hold_in) m_hold = 0;
    end else if (hold_in) begin
      m_hold = 1;
    end else if (m_auto) begin
      if (en || m_cnt == DW - 1) begin m_sel = (m_sel + 1) % N; m_cnt = 0; end
      else m_cnt++;
      if (em) m_auto = 0;
    end else begin
      if (en) m_sel = (m_sel + 1) % N;
      if (em) begin m_auto = 1; m_cnt = 0; end
    end
    for (int i = 0; i < N; i++)
      if (ch_valid[i]) begin m_sh[i] = ch_data[i*W +: W]; m_seen[i] = 1; end
    m_dp = (fmt_select == 2'b01 ? 4'b0010 : 4'b0000) | (m_hold ? 4'b1000 : 4'b0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_model();
    chk("rand_sel",   32'(sel_out),    32'(m_sel));
    chk("rand_disp",  32'(disp_data),  32'(m_disp));
    chk("rand_dp",    32'(decimal_pt), 32'(m_dp));
    chk("rand_auto",  32'(mode_auto),  32'(m_auto));
    chk("rand_stale", 32'(disp_stale), 32'(m_stale));
  endtask

  task automatic idle();
    btn_next = 0; btn_mode = 0; hold_in = 0; ch_valid = '0; ch_data = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    fmt_select = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic dwell_expect(input int n, input int s0, input int s1);
    repeat (n - 1) begin tick(); chk("dwell_wait", 32'(sel_out), 32'(s0)); end
    tick();
    chk("dwell_step", 32'(sel_out), 32'(s1));
  endtask

  typedef struct {
    logic bn, bm, hold;
    logic [1:0] fmt;
    logic [N-1:0] cv;
    logic [N*W-1:0] cd;
    logic [1:0] sel;
    logic [W-1:0] disp;
    logic [3:0] dp;
    logic au, st;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0,0,0,2'b01,4'b0000,64'h0,                 2'd0,16'h0000,4'h2,0,1};
    tbl[1]  = '{1,0,0,2'b01,4'b0000,64'h0,                 2'd1,16'h0000,4'h2,0,1};
    tbl[2]  = '{0,0,0,2'b01,4'b0000,64'h0,                 2'd1,16'h0000,4'h2,0,1};
    tbl[3]  = '{1,0,0,2'b01,4'b0000,64'h0,                 2'd2,16'h0000,4'h2,0,1};
    tbl[4]  = '{0,0,0,2'b01,4'b0100,64'h0000_0421_0000_0000,2'd2,16'h0000,4'h2,0,1};
    tbl[5]  = '{0,0,0,2'b01,4'b0000,64'h0,                 2'd2,16'h0421,4'h2,0,0};
    tbl[6]  = '{1,0,0,2'b01,4'b0000,64'h0,                 2'd3,16'h0421,4'h2,0,0};
    tbl[7]  = '{0,0,0,2'b01,4'b0000,64'h0,                 2'd3,16'h0000,4'h2,0,1};
    tbl[8]  = '{1,1,0,2'b01,4'b0000,64'h0,                 2'd0,16'h0000,4'h2,1,1};
    tbl[9]  = '{0,0,0,2'b01,4'b0000,64'h0,                 2'd0,16'h0000,4'h2,1,1};
    tbl[10] = '{0,0,1,2'b00,4'b0000,64'h0,                 2'd0,16'h0000,4'h8,1,1};
    tbl[11] = '{1,0,1,2'b00,4'b0001,64'h0000_0000_0000_1111,2'd0,16'h0000,4'h8,1,1};
    tbl[12] = '{0,0,0,2'b11,4'b0000,64'h0,                 2'd0,16'h0000,4'h0,1,1};
    tbl[13] = '{0,0,0,2'b01,4'b0000,64'h0,                 2'd0,16'h1111,4'h2,1,0};

    // Reset state
    do_reset();
    chk("rst_sel",   32'(sel_out),    32'd0);
    chk("rst_disp",  32'(disp_data),  32'd0);
    chk("rst_dp",    32'(decimal_pt), 32'd0);
    chk("rst_auto",  32'(mode_auto),  32'd0);
    chk("rst_stale", 32'(disp_stale), 32'd1);

    // Table: manual stepping, data lag, simultaneous edges, hold/resume
    foreach (tbl[k]) begin
      btn_next = tbl[k].bn; btn_mode = tbl[k].bm; hold_in = tbl[k].hold;
      fmt_select = tbl[k].fmt; ch_valid = tbl[k].cv; ch_data = tbl[k].cd;
      tick();
      chk($sformatf("tbl%0d_sel", k),   32'(sel_out),    32'(tbl[k].sel));
      chk($sformatf("tbl%0d_disp", k),  32'(disp_data),  32'(tbl[k].disp));
      chk($sformatf("tbl%0d_dp", k),    32'(decimal_pt), 32'(tbl[k].dp));
      chk($sformatf("tbl%0d_auto", k),  32'(mode_auto),  32'(tbl[k].au));
      chk($sformatf("tbl%0d_stale", k), 32'(disp_stale), 32'(tbl[k].st));
    end
    idle();

    // Auto dwell timing and a manual advance mid-dwell
    do_reset();
    btn_mode = 1; tick(); btn_mode = 0;
    chk("auto_enter", 32'(mode_auto), 32'd1);
    dwell_expect(DW, 0, 1);
    repeat (5) tick();
    chk("dwell_mid", 32'(sel_out), 32'd1);
    btn_next = 1; tick(); btn_next = 0;
    chk("next_immediate", 32'(sel_out), 32'd2);
    dwell_expect(DW, 2, 3);

    // Reset during HOLD entered from AUTO
    do_reset();
    ch_valid = 4'b0001; ch_data = 64'h0000_0000_0000_abcd; tick();
    idle(); tick(); tick();
    chk("pre_disp", 32'(disp_data), 32'h0000abcd);
    btn_mode = 1; tick(); btn_mode = 0;
    hold_in = 1; tick(); tick();
    chk("hold_dp", 32'(decimal_pt), 32'h8);
    chk("hold_auto", 32'(mode_auto), 32'd1);
    #3 reset = 0;
    btn_next = 1; hold_in = 0;
    #1;
    chk("arst_sel",   32'(sel_out),    32'd0);
    chk("arst_disp",  32'(disp_data),  32'd0);
    chk("arst_dp",    32'(decimal_pt), 32'd0);
    chk("arst_auto",  32'(mode_auto),  32'd0);
    chk("arst_stale", 32'(disp_stale), 32'd1);
    model_reset();
    @(posedge clk); #1 reset = 1;
    tick();
    chk("post_rst_edge", 32'(sel_out),   32'd1);
    chk("post_rst_man",  32'(mode_auto), 32'd0);
    btn_next = 0; tick();

    // Randomised run against the reference model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      btn_next = ($urandom_range(0, 3) == 0);
      btn_mode = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) hold_in = ~hold_in;
      fmt_select = 2'($urandom_range(0, 3));
      ch_valid = 4'($urandom) & 4'($urandom);
      ch_data = {$urandom, $urandom};
      tick();
      chk_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
